// File: rtl/ddr3_app_pkg.sv
// Shared constants and state encoding for the DDR3 application-side sequencer.
package ddr3_app_pkg;

    localparam logic [2:0] CMD_RD = 3'b001;
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam int         BEAT_W = 288;
    localparam int         MASK_W = 36;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WD0,
        ST_WD1
    } state_e;

endpackage

// File: rtl/ddr3_rd_collect.sv
// Gathers two-beat read returns into one response word and tracks how many
// issued reads are still waiting for their end beat.
module ddr3_rd_collect
    import ddr3_app_pkg::*;
#(
    parameter int RD_CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  rd_issue,
    input  logic [BEAT_W-1:0]     rd_data,
    input  logic                  rd_valid,
    input  logic                  rd_end,
    output logic                  rsp_valid,
    output logic [2*BEAT_W-1:0]   rsp_data,
    output logic [RD_CNT_W-1:0]   rd_pending,
    output logic                  err_spurious
);

    logic                rsp_valid_q, rsp_valid_d;
    logic [RD_CNT_W-1:0] pend_q, pend_d;
    logic                err_q, err_d;
    logic                burst_done;

    // Half 0 takes non-end beats, half 1 takes the end beat; a lone end beat
    // therefore leaves half 0 holding whatever it had before.
    for (genvar gi = 0; gi < 2; gi++) begin : g_half
        logic [BEAT_W-1:0] half_q, half_d;

        always_comb begin
            half_d = half_q;
            if (rd_valid && (rd_end == (gi != 0))) begin
                half_d = rd_data;
            end
        end

        always_ff @(posedge clk) begin
            if (srst) begin
                half_q <= '0;
            end else begin
                half_q <= half_d;
            end
        end

        assign rsp_data[gi*BEAT_W +: BEAT_W] = half_q;
    end

    assign burst_done = rd_valid && rd_end && (pend_q != '0);

    always_comb begin
        pend_d      = pend_q;
        rsp_valid_d = rd_valid && rd_end;
        err_d       = err_q || (rd_valid && (pend_q == '0));
        if (rd_issue && !burst_done) begin
            pend_d = pend_q + RD_CNT_W'(1);
        end else if (!rd_issue && burst_done) begin
            pend_d = pend_q - RD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rsp_valid_q <= 1'b0;
            pend_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rd_pending   = pend_q;
    assign err_spurious = err_q;

endmodule

// File: rtl/ddr3_app_sequencer.sv
// Issues one whole-burst request at a time onto the DDR3 controller app port
// and frames the two write-data beats; read returns go through ddr3_rd_collect.
module ddr3_app_sequencer
    import ddr3_app_pkg::*;
#(
    parameter int MAX_RD   = 4,
    parameter int RD_CNT_W = 4
) (
    input  logic                  ddr3_clk,
    input  logic                  ddr3_rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rnw,
    input  logic [31:0]           req_addr,
    input  logic [2*BEAT_W-1:0]   req_wdata,
    input  logic [2*MASK_W-1:0]   req_wmask,
    output logic [2:0]            ddr3_cmd,
    output logic [31:0]           ddr3_addr,
    output logic                  ddr3_en,
    input  logic                  ddr3_rdy,
    output logic [BEAT_W-1:0]     ddr3_wdf_data,
    output logic [MASK_W-1:0]     ddr3_wdf_mask,
    output logic                  ddr3_wdf_wren,
    output logic                  ddr3_wdf_end,
    input  logic                  ddr3_wdf_rdy,
    input  logic [BEAT_W-1:0]     ddr3_rd_data,
    input  logic                  ddr3_rd_data_valid,
    input  logic                  ddr3_rd_data_end,
    output logic                  rsp_valid,
    output logic [2*BEAT_W-1:0]   rsp_data,
    output logic [RD_CNT_W-1:0]   rd_pending,
    output logic                  err_spurious
);

    state_e                state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic                  rnw_q, rnw_d;
    logic [2*BEAT_W-1:0]   wdata_q, wdata_d;
    logic [2*MASK_W-1:0]   wmask_q, wmask_d;
    logic                  rd_full;
    logic                  rd_issue;

    // Only reads are held back when the response path is full; writes pass.
    assign rd_full = (rd_pending == RD_CNT_W'(MAX_RD));

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rnw_d         = rnw_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        req_ready     = 1'b0;
        ddr3_en       = 1'b0;
        ddr3_wdf_wren = 1'b0;
        ddr3_wdf_end  = 1'b0;
        ddr3_wdf_data = '0;
        ddr3_wdf_mask = '0;
        rd_issue      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = !(req_valid && req_rnw && rd_full);
                if (req_valid && req_ready) begin
                    addr_d  = req_addr;
                    rnw_d   = req_rnw;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                ddr3_en = 1'b1;
                if (ddr3_rdy) begin
                    rd_issue = rnw_q;
                    state_d  = rnw_q ? ST_IDLE : ST_WD0;
                end
            end
            ST_WD0: begin
                ddr3_wdf_wren = 1'b1;
                ddr3_wdf_data = wdata_q[BEAT_W-1:0];
                ddr3_wdf_mask = wmask_q[MASK_W-1:0];
                if (ddr3_wdf_rdy) begin
                    state_d = ST_WD1;
                end
            end
            default: begin
                ddr3_wdf_wren = 1'b1;
                ddr3_wdf_end  = 1'b1;
                ddr3_wdf_data = wdata_q[2*BEAT_W-1:BEAT_W];
                ddr3_wdf_mask = wmask_q[2*MASK_W-1:MASK_W];
                if (ddr3_wdf_rdy) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge ddr3_clk) begin
        if (ddr3_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rnw_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rnw_q   <= rnw_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    assign ddr3_cmd  = rnw_q ? CMD_RD : CMD_WR;
    assign ddr3_addr = addr_q;

    ddr3_rd_collect #(
        .RD_CNT_W (RD_CNT_W)
    ) u_rd_collect (
        .clk          (ddr3_clk),
        .srst         (ddr3_rst),
        .rd_issue     (rd_issue),
        .rd_data      (ddr3_rd_data),
        .rd_valid     (ddr3_rd_data_valid),
        .rd_end       (ddr3_rd_data_end),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rd_pending   (rd_pending),
        .err_spurious (err_spurious)
    );

endmodule

// File: tb/tb_ddr3_app_sequencer.sv
// Bench for ddr3_app_sequencer: table-driven request vectors, directed corner
// sequences, then randomized traffic against a transaction-level model.
module tb_ddr3_app_sequencer;

    localparam int MAX_RD = 4;
    localparam int NREQ   = 300;

    typedef struct {
        logic         rnw;
        logic [31:0]  addr;
        logic [575:0] wdata;
        logic [71:0]  wmask;
        int           cs;
        int           s0;
        int           s1;
        logic [2:0]   exp_cmd;
        int           exp_en;
        int           exp_b0;
        int           exp_b1;
        int           exp_tot;
    } vec_t;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [31:0] addr;
    } cmd_t;

    typedef struct packed {
        logic [287:0] d;
        logic [35:0]  m;
        logic         last;
    } beat_t;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_rnw;
    logic [31:0]  req_addr;
    logic [575:0] req_wdata;
    logic [71:0]  req_wmask;
    logic [2:0]   ddr3_cmd;
    logic [31:0]  ddr3_addr;
    logic         ddr3_en;
    logic         ddr3_rdy;
    logic [287:0] ddr3_wdf_data;
    logic [35:0]  ddr3_wdf_mask;
    logic         ddr3_wdf_wren;
    logic         ddr3_wdf_end;
    logic         ddr3_wdf_rdy;
    logic [287:0] rd_data;
    logic         rd_valid;
    logic         rd_end;
    logic         rsp_valid;
    logic [575:0] rsp_data;
    logic [3:0]   rd_pending;
    logic         err_spurious;

    int total;
    int bad;

    ddr3_app_sequencer #(
        .MAX_RD   (MAX_RD),
        .RD_CNT_W (4)
    ) dut (
        .ddr3_clk           (clk),
        .ddr3_rst           (rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_rnw            (req_rnw),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .req_wmask          (req_wmask),
        .ddr3_cmd           (ddr3_cmd),
        .ddr3_addr          (ddr3_addr),
        .ddr3_en            (ddr3_en),
        .ddr3_rdy           (ddr3_rdy),
        .ddr3_wdf_data      (ddr3_wdf_data),
        .ddr3_wdf_mask      (ddr3_wdf_mask),
        .ddr3_wdf_wren      (ddr3_wdf_wren),
        .ddr3_wdf_end       (ddr3_wdf_end),
        .ddr3_wdf_rdy       (ddr3_wdf_rdy),
        .ddr3_rd_data       (rd_data),
        .ddr3_rd_data_valid (rd_valid),
        .ddr3_rd_data_end   (rd_end),
        .rsp_valid          (rsp_valid),
        .rsp_data           (rsp_data),
        .rd_pending         (rd_pending),
        .err_spurious       (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [575:0] act, input logic [575:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [287:0] rnd288();
        logic [287:0] r;
        for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic vec_t mk(input logic rnw, input logic [31:0] a, input logic [575:0] d,
                                input logic [71:0] m, input int cs, input int s0, input int s1,
                                input logic [2:0] ec, input int een, input int eb0, input int eb1,
                                input int etot);
        vec_t v;
        v.rnw = rnw; v.addr = a; v.wdata = d; v.wmask = m;
        v.cs = cs; v.s0 = s0; v.s1 = s1;
        v.exp_cmd = ec; v.exp_en = een; v.exp_b0 = eb0; v.exp_b1 = eb1; v.exp_tot = etot;
        return v;
    endfunction

    // Presents one request, stalls the controller as the vector asks, and
    // counts cycles of each phase until req_ready returns.
    task automatic run_req(input vec_t v, output int en_n, output int b0_n, output int b1_n,
                           output int tot_n, output int ov_n);
        en_n = 0; b0_n = 0; b1_n = 0; tot_n = 0; ov_n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_rnw = v.rnw; req_addr = v.addr;
        req_wdata = v.wdata; req_wmask = v.wmask;
        ddr3_rdy = 1'b0; ddr3_wdf_rdy = 1'b0;
        #1 chk("req_accept_ready", 576'(req_ready), 576'(1));
        for (int c = 0; c < 64; c++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            ddr3_rdy = ddr3_en && (en_n == v.cs);
            ddr3_wdf_rdy = ddr3_wdf_wren && (ddr3_wdf_end ? (b1_n == v.s1) : (b0_n == v.s0));
            #1;
            tot_n++;
            if (req_ready) break;
            if (ddr3_en) begin
                en_n++;
                chk("cmd_addr", 576'({ddr3_cmd, ddr3_addr}), 576'({v.exp_cmd, v.addr}));
            end
            if (ddr3_wdf_wren && !ddr3_wdf_end) begin
                b0_n++;
                chk("beat0", 576'({ddr3_wdf_mask, ddr3_wdf_data}), 576'({v.wmask[35:0], v.wdata[287:0]}));
            end
            if (ddr3_wdf_wren && ddr3_wdf_end) begin
                b1_n++;
                chk("beat1", 576'({ddr3_wdf_mask, ddr3_wdf_data}), 576'({v.wmask[71:36], v.wdata[575:288]}));
            end
            if (!ddr3_wdf_wren) chk("wdf_idle_zero", 576'({ddr3_wdf_end, ddr3_wdf_mask, ddr3_wdf_data}), 576'(0));
            if (ddr3_en && ddr3_wdf_wren) ov_n++;
        end
        ddr3_rdy = 1'b0; ddr3_wdf_rdy = 1'b0;
    endtask

    task automatic send_burst(input logic [287:0] d0, input logic [287:0] d1);
        @(posedge clk); #1; rd_valid = 1'b1; rd_end = 1'b0; rd_data = d0;
        @(posedge clk); #1; rd_end = 1'b1; rd_data = d1;
        @(posedge clk); #1; rd_valid = 1'b0; rd_end = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    vec_t         tbl[5];
    vec_t         rd_v;
    int           en_n, b0_n, b1_n, tot_n, ov_n;
    logic [575:0] p5a, p3c;
    logic [287:0] b11, b22, b33, x0, x1;

    cmd_t         m_cmd_q[$];
    beat_t        m_beat_q[$];
    cmd_t         ce;
    beat_t        be;
    int           n_sent, ret_phase, m_pend;
    logic         acc, m_rsp_due, done;
    logic [575:0] m_rsp;
    logic [287:0] m_first;

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; req_valid = 1'b0; req_rnw = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        ddr3_rdy = 1'b0; ddr3_wdf_rdy = 1'b0; rd_data = '0; rd_valid = 1'b0; rd_end = 1'b0;
        p5a = {{36{8'hA5}}, {36{8'h5A}}};
        p3c = {{36{8'hC3}}, {36{8'h3C}}};
        b11 = {36{8'h11}}; b22 = {36{8'h22}}; b33 = {36{8'h33}};

        // rnw addr data mask cs s0 s1 | cmd en b0 b1 total-cycles
        tbl[0] = mk(1'b0, 32'h0000_1000, p5a, {36'h0_0000_00F0, 36'h0_0000_000F}, 0, 0, 0, 3'b000, 1, 1, 1, 4);
        tbl[1] = mk(1'b0, 32'h0000_1000, p5a, {36'h0_0000_00F0, 36'h0_0000_000F}, 3, 0, 2, 3'b000, 4, 1, 3, 9);
        tbl[2] = mk(1'b0, 32'h0000_2040, p3c, {36'hF_0000_0000, 36'h0_0000_0001}, 1, 2, 0, 3'b000, 2, 3, 1, 7);
        tbl[3] = mk(1'b0, 32'hDEAD_BEE0, p3c, 72'h0, 0, 1, 1, 3'b000, 1, 2, 2, 6);
        tbl[4] = mk(1'b1, 32'h0000_0040, '0, 72'h0, 2, 0, 0, 3'b001, 3, 0, 0, 4);
        rd_v   = mk(1'b1, 32'h0000_0100, '0, 72'h0, 0, 0, 0, 3'b001, 1, 0, 0, 2);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_req_ready", 576'(req_ready), 576'(1));
        chk("rst_ctrl", 576'({ddr3_en, ddr3_wdf_wren, ddr3_wdf_end, rsp_valid, err_spurious}), 576'(0));
        chk("rst_pending", 576'(rd_pending), 576'(0));
        chk("rst_cmd_addr", 576'({ddr3_cmd, ddr3_addr}), 576'(0));
        chk("rst_rsp_data", rsp_data, 576'(0));
        chk("rst_wdf", 576'({ddr3_wdf_mask, ddr3_wdf_data}), 576'(0));

        for (int i = 0; i < 5; i++) begin
            run_req(tbl[i], en_n, b0_n, b1_n, tot_n, ov_n);
            chk($sformatf("tbl%0d_en_cycles", i), 576'(en_n), 576'(tbl[i].exp_en));
            chk($sformatf("tbl%0d_beat0_cycles", i), 576'(b0_n), 576'(tbl[i].exp_b0));
            chk($sformatf("tbl%0d_beat1_cycles", i), 576'(b1_n), 576'(tbl[i].exp_b1));
            chk($sformatf("tbl%0d_period", i), 576'(tot_n), 576'(tbl[i].exp_tot));
            chk($sformatf("tbl%0d_data_before_cmd", i), 576'(ov_n), 576'(0));
        end

        // Read at 0x40 (last table row) returns two beats.
        chk("rd_pending_one", 576'(rd_pending), 576'(1));
        @(posedge clk); #1; rd_valid = 1'b1; rd_end = 1'b0; rd_data = b11;
        @(posedge clk); #1; rd_end = 1'b1; rd_data = b22;
        #1 chk("rsp_not_early", 576'(rsp_valid), 576'(0));
        @(posedge clk); #1; rd_valid = 1'b0; rd_end = 1'b0;
        #1;
        chk("rsp_pulse", 576'(rsp_valid), 576'(1));
        chk("rsp_data", rsp_data, {b22, b11});
        chk("rd_pending_zero", 576'(rd_pending), 576'(0));
        @(posedge clk); #2;
        chk("rsp_one_cycle", 576'(rsp_valid), 576'(0));
        chk("rsp_data_hold", rsp_data, {b22, b11});

        // Fill the read window, then a fifth read must stall while writes pass.
        for (int i = 0; i < MAX_RD; i++) begin
            run_req(rd_v, en_n, b0_n, b1_n, tot_n, ov_n);
            chk("fill_read_period", 576'(tot_n), 576'(2));
        end
        chk("pending_full", 576'(rd_pending), 576'(MAX_RD));
        @(posedge clk); #1; req_valid = 1'b1; req_rnw = 1'b1; req_addr = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fifth_read_stall", 576'(req_ready), 576'(0));
            chk("fifth_read_no_cmd", 576'(ddr3_en), 576'(0));
            @(posedge clk); #1;
        end
        req_rnw = 1'b0;
        #1 chk("write_not_stalled", 576'(req_ready), 576'(1));
        req_valid = 1'b0;
        run_req(tbl[0], en_n, b0_n, b1_n, tot_n, ov_n);
        chk("write_while_full_period", 576'(tot_n), 576'(4));
        chk("write_while_full_beats", 576'(b0_n + b1_n), 576'(2));
        send_burst(rnd288(), rnd288());
        #1 chk("pending_after_one_return", 576'(rd_pending), 576'(MAX_RD - 1));
        run_req(rd_v, en_n, b0_n, b1_n, tot_n, ov_n);
        chk("fifth_read_issued", 576'(en_n), 576'(1));
        chk("pending_full_again", 576'(rd_pending), 576'(MAX_RD));
        for (int i = 0; i < MAX_RD; i++) send_burst(rnd288(), rnd288());
        #1 chk("pending_drained", 576'(rd_pending), 576'(0));

        // Read command handshake in the same cycle as another burst's end beat.
        run_req(rd_v, en_n, b0_n, b1_n, tot_n, ov_n);
        x0 = rnd288(); x1 = rnd288();
        @(posedge clk); #1;
        req_valid = 1'b1; req_rnw = 1'b1; req_addr = 32'h0000_0080;
        rd_valid = 1'b1; rd_end = 1'b0; rd_data = x0;
        @(posedge clk); #1;
        req_valid = 1'b0; ddr3_rdy = 1'b1; rd_end = 1'b1; rd_data = x1;
        #1;
        chk("coincide_cmd_en", 576'(ddr3_en), 576'(1));
        chk("coincide_pending_before", 576'(rd_pending), 576'(1));
        @(posedge clk); #1;
        ddr3_rdy = 1'b0; rd_valid = 1'b0; rd_end = 1'b0;
        #1;
        chk("coincide_pending_after", 576'(rd_pending), 576'(1));
        chk("coincide_rsp", rsp_data, {x1, x0});
        send_burst(rnd288(), rnd288());
        #1 chk("coincide_drained", 576'(rd_pending), 576'(0));

        // Unsolicited end beat straight after reset.
        do_reset();
        #1 chk("spur_clear_after_rst", 576'(err_spurious), 576'(0));
        rd_valid = 1'b1; rd_end = 1'b1; rd_data = b33;
        @(posedge clk); #1; rd_valid = 1'b0; rd_end = 1'b0;
        #1;
        chk("spur_flag", 576'(err_spurious), 576'(1));
        chk("spur_no_underflow", 576'(rd_pending), 576'(0));
        chk("spur_rsp_pulse", 576'(rsp_valid), 576'(1));
        chk("spur_rsp_data", rsp_data, {b33, 288'h0});
        @(posedge clk); #2;
        chk("spur_sticky", 576'(err_spurious), 576'(1));

        // Reset while parked in the first write beat, with a read outstanding.
        run_req(rd_v, en_n, b0_n, b1_n, tot_n, ov_n);
        @(posedge clk); #1;
        req_valid = 1'b1; req_rnw = 1'b0; req_addr = 32'h0000_3000; req_wdata = p5a; req_wmask = '0;
        ddr3_rdy = 1'b1; ddr3_wdf_rdy = 1'b0;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        #1 chk("mid_wd0_wren", 576'({ddr3_wdf_wren, ddr3_wdf_end}), 576'(2'b10));
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; ddr3_rdy = 1'b0;
        #1;
        chk("rst_mid_wren", 576'({ddr3_wdf_wren, ddr3_en}), 576'(0));
        chk("rst_mid_ready", 576'(req_ready), 576'(1));
        chk("rst_mid_pending", 576'(rd_pending), 576'(0));
        chk("rst_mid_err", 576'(err_spurious), 576'(0));
        chk("rst_mid_regs", 576'({ddr3_cmd, ddr3_addr}), 576'(0));
        chk("rst_mid_rsp", rsp_data, 576'(0));

        // Randomized traffic against a request/command/beat queue model.
        n_sent = 0; ret_phase = 0; m_pend = 0; acc = 1'b0; m_rsp_due = 1'b0; done = 1'b0;
        m_rsp = '0; m_first = '0;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(posedge clk); #1;
            if (acc) begin req_valid = 1'b0; acc = 1'b0; end
            if (!req_valid && n_sent < NREQ && $urandom_range(0, 2) != 0) begin
                req_rnw   = 1'($urandom_range(0, 1));
                req_addr  = $urandom;
                req_wdata = {rnd288(), rnd288()};
                req_wmask = 72'({$urandom, $urandom, $urandom});
                req_valid = 1'b1;
                n_sent++;
            end
            ddr3_rdy     = ($urandom_range(0, 3) != 0);
            ddr3_wdf_rdy = ($urandom_range(0, 3) != 0);
            rd_valid = 1'b0; rd_end = 1'b0;
            if (ret_phase == 0) begin
                if (m_pend > 0 && $urandom_range(0, 2) == 0) begin
                    rd_data = rnd288(); rd_valid = 1'b1; ret_phase = 1;
                end
            end else if ($urandom_range(0, 1) == 0) begin
                rd_data = rnd288(); rd_valid = 1'b1; rd_end = 1'b1; ret_phase = 0;
            end

            @(negedge clk);
            chk("rnd_req_ready", 576'(req_ready),
                576'((m_cmd_q.size() == 0) && (m_beat_q.size() == 0) &&
                     !(req_valid && req_rnw && m_pend == MAX_RD)));
            chk("rnd_pending", 576'(rd_pending), 576'(m_pend));
            chk("rnd_rsp_valid", 576'(rsp_valid), 576'(m_rsp_due));
            if (m_rsp_due) chk("rnd_rsp_data", rsp_data, m_rsp);
            m_rsp_due = 1'b0;
            if (!ddr3_wdf_wren) chk("rnd_wdf_idle_zero", 576'({ddr3_wdf_mask, ddr3_wdf_data}), 576'(0));

            if (ddr3_en && ddr3_rdy) begin
                if (m_cmd_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rnd_cmd_unexpected: got cmd %0h addr %0h, required no command", ddr3_cmd, ddr3_addr);
                end else begin
                    ce = m_cmd_q.pop_front();
                    chk("rnd_cmd", 576'({ddr3_cmd, ddr3_addr}), 576'(ce));
                    if (ce.cmd == 3'b001) m_pend++;
                end
            end
            if (ddr3_wdf_wren && ddr3_wdf_rdy) begin
                if (m_beat_q.size() == 0 || m_cmd_q.size() != 0) begin
                    total++; bad++;
                    $display("FAIL rnd_beat_unexpected: got beat %0h, required no beat before command", ddr3_wdf_data);
                end else begin
                    be = m_beat_q.pop_front();
                    chk("rnd_beat", 576'({ddr3_wdf_data, ddr3_wdf_mask, ddr3_wdf_end}), 576'(be));
                end
            end
            if (rd_valid) begin
                if (!rd_end) begin
                    m_first = rd_data;
                end else begin
                    m_rsp = {rd_data, m_first};
                    m_rsp_due = 1'b1;
                    if (m_pend > 0) m_pend--;
                end
            end
            if (req_valid && req_ready) begin
                acc = 1'b1;
                ce.cmd = req_rnw ? 3'b001 : 3'b000;
                ce.addr = req_addr;
                m_cmd_q.push_back(ce);
                if (!req_rnw) begin
                    m_beat_q.push_back({req_wdata[287:0], req_wmask[35:0], 1'b0});
                    m_beat_q.push_back({req_wdata[575:288], req_wmask[71:36], 1'b1});
                end
            end
            done = (n_sent == NREQ) && !req_valid && (m_cmd_q.size() == 0) && (m_beat_q.size() == 0) &&
                   (m_pend == 0) && (ret_phase == 0) && !m_rsp_due;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL rnd_drain: got %0d requests with work outstanding after cycle budget, required all retired", n_sent);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
